// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, reset PC and IF/ID field layout.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  localparam int IFID_PC4_HI   = 63;
  localparam int IFID_PC4_LO   = 32;
  localparam int IFID_INSTR_HI = 31;
  localparam int IFID_INSTR_LO = 0;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_npc.sv
// Next-PC select: sequential pc+4, or a word-aligned redirect target with jump over branch.
module if_npc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc_redir
);

  always_comb begin
    pc_plus4 = pc + 32'd4;
    if (jump) begin
      npc_redir = align_word(jump_target);
    end else if (branch_taken) begin
      npc_redir = align_word(branch_target);
    end else begin
      npc_redir = pc_plus4;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and drives the IF/ID register.
module if_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWr,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [63:0] IFID_in,
  output logic        IFIDWr,
  output logic        rstIFID
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  shadow_q, shadow_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  npc_redir;
  logic         redir;
  logic         outstanding;

  if_npc u_npc (
    .pc            (pc_q),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_plus4      (pc_plus4),
    .npc_redir     (npc_redir)
  );

  assign redir       = (jump | branch_taken) & PCWr;
  assign outstanding = (state_q != ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      shadow_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      shadow_q <= shadow_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    shadow_d = shadow_q;
    hold_d   = hold_q;
    if (redir) begin
      pc_d = npc_redir;
      // An unacked fetch must still complete on its original address before the target is requested.
      if (outstanding && !imem_ack) begin
        state_d  = ST_DRAIN;
        shadow_d = imem_addr;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ack) begin
            if (PCWr) begin
              pc_d = pc_plus4;
            end else begin
              hold_d  = imem_rdata;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (PCWr) begin
            pc_d    = pc_plus4;
            state_d = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req  = !rst && outstanding;
    imem_addr = (state_q == ST_DRAIN) ? shadow_q : pc_q;
    pc        = pc_q;
    rstIFID   = rst | redir;
    IFIDWr    = 1'b0;
    IFID_in   = '0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          IFID_in = {pc_plus4, imem_rdata};
          IFIDWr  = imem_ack & PCWr & !redir;
        end
        ST_HOLD: begin
          IFID_in = {pc_plus4, hold_q};
          IFIDWr  = PCWr & !redir;
        end
        default: begin
          IFID_in = '0;
          IFIDWr  = 1'b0;
        end
      endcase
    end
  end

endmodule
